// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix geometry, function-key codes, FSM and scan-result types.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
//
// Imported by the keypad encoder and by the calculator core and its benches,
// so the keycode constants below are the single source of truth.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 6;

    // Function keys occupy matrix indices 16..23 in this order.
    localparam logic [4:0] KEY_SQR    = 5'h01;
    localparam logic [4:0] KEY_CHSIGN = 5'h02;
    localparam logic [4:0] KEY_EQUALS = 5'h03;
    localparam logic [4:0] KEY_CA     = 5'h04;
    localparam logic [4:0] KEY_MULTI  = 5'h09;
    localparam logic [4:0] KEY_MINUS  = 5'h0A;
    localparam logic [4:0] KEY_PLUS   = 5'h0B;
    localparam logic [4:0] KEY_CE     = 5'h0C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_STROBE,
        ST_HELD
    } kp_state_t;

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_SINGLE,
        SCAN_MULTI
    } scan_res_t;

    // Key index = col*4 + row. Indices 0..15 are hex digits tagged with bit 4,
    // indices 16..23 are the function keys.
    function automatic logic [4:0] index_to_keycode(input logic [4:0] idx);
        logic [4:0] kc;
        kc = 5'h00;
        if (idx < 5'd16) begin
            kc = {1'b1, idx[3:0]};
        end else begin
            case (idx[2:0])
                3'd0:    kc = KEY_SQR;
                3'd1:    kc = KEY_CHSIGN;
                3'd2:    kc = KEY_EQUALS;
                3'd3:    kc = KEY_CA;
                3'd4:    kc = KEY_MULTI;
                3'd5:    kc = KEY_MINUS;
                3'd6:    kc = KEY_PLUS;
                default: kc = KEY_CE;
            endcase
        end
        return kc;
    endfunction

endpackage

// File: rtl/keypad_scan_core.sv
// Column scanner: drives one active-low column per slot, synchronises rows, classifies each full scan.
// Latency: rows seen 2 cycles after a column is driven; o_scan_done pulses 1 cycle after the column-5 sample.
// Backpressure: none; a scan result is presented for exactly one cycle and must be consumed then.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_row_n[3:0]     raw row returns (asynchronous, low = closed)
//   o_col_n[5:0]     one-hot active-low column drive
//   o_scan_done      one-cycle pulse after each complete 6-column scan
//   o_result         NONE / SINGLE / MULTI for the scan just completed
//   o_idx[4:0]       key index (col*4+row) when o_result is SINGLE
module keypad_scan_core
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_row_n,
    output logic [5:0]  o_col_n,
    output logic        o_scan_done,
    output scan_res_t   o_result,
    output logic [4:0]  o_idx
);

    localparam int                SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [2:0]        COL_LAST  = 3'(NUM_COLS - 1);

    logic [3:0]        r_sync1;
    logic [3:0]        r_sync2;
    logic [SLOT_W-1:0] r_slot;
    logic [2:0]        r_col;
    logic [5:0]        r_col_n;
    // Closures seen so far in this scan, saturating at 2 (2 means "many").
    logic [1:0]        r_acc_cnt;
    logic [4:0]        r_acc_idx;
    logic              r_done;
    scan_res_t         r_result;
    logic [4:0]        r_idx;

    logic [3:0]        w_hits;
    logic [2:0]        w_sum;
    logic [1:0]        w_col_cnt;
    logic [1:0]        w_row;
    logic [2:0]        w_tot;
    logic [1:0]        w_tot_sat;
    logic [4:0]        w_idx;
    logic              w_slot_end;
    logic              w_last_col;

    assign w_hits     = ~r_sync2;
    assign w_slot_end = (r_slot == SLOT_LAST);
    assign w_last_col = (r_col == COL_LAST);

    always_comb begin
        w_sum = 3'd0;
        w_row = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (w_hits[r]) begin
                w_row = 2'(r);
            end
            w_sum = w_sum + 3'(w_hits[r]);
        end
        w_col_cnt = (w_sum > 3'd1) ? 2'd2 : w_sum[1:0];
        w_tot     = 3'(r_acc_cnt) + 3'(w_col_cnt);
        w_tot_sat = (w_tot > 3'd1) ? 2'd2 : w_tot[1:0];
        // Only meaningful when the running total is exactly one: the single
        // closure is either the one already recorded or the one in this column.
        w_idx     = (r_acc_cnt == 2'd0) ? {r_col, w_row} : r_acc_idx;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 4'hF;
            r_sync2   <= 4'hF;
            r_slot    <= '0;
            r_col     <= 3'd0;
            r_col_n   <= 6'b111110;
            r_acc_cnt <= 2'd0;
            r_acc_idx <= 5'd0;
            r_done    <= 1'b0;
            r_result  <= SCAN_NONE;
            r_idx     <= 5'd0;
        end else begin
            r_sync1 <= i_row_n;
            r_sync2 <= r_sync1;
            r_done  <= 1'b0;
            if (w_slot_end) begin
                r_slot  <= '0;
                r_col   <= w_last_col ? 3'd0 : r_col + 3'd1;
                r_col_n <= w_last_col ? 6'b111110 : {r_col_n[4:0], r_col_n[5]};
                if (w_last_col) begin
                    r_done    <= 1'b1;
                    r_idx     <= w_idx;
                    r_acc_cnt <= 2'd0;
                    r_acc_idx <= 5'd0;
                    case (w_tot_sat)
                        2'd0:    r_result <= SCAN_NONE;
                        2'd1:    r_result <= SCAN_SINGLE;
                        default: r_result <= SCAN_MULTI;
                    endcase
                end else begin
                    r_acc_cnt <= w_tot_sat;
                    r_acc_idx <= w_idx;
                end
            end else begin
                r_slot <= r_slot + SLOT_W'(1);
            end
        end
    end

    assign o_col_n     = r_col_n;
    assign o_scan_done = r_done;
    assign o_result    = r_result;
    assign o_idx       = r_idx;

endmodule

// File: rtl/keypad_encoder.sv
// Keypad encoder: scans a 4x6 key matrix, debounces one press and emits its 5-bit keycode with a newkey strobe.
// Latency: keycode loads 1 cycle after the accepting scan completes; newkey follows 1 cycle later.
// Backpressure: none; newkey is a one-cycle strobe the consumer must catch.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   row_n[3:0]   matrix row returns, low = key closed to the driven column
//   col_n[5:0]   one-hot active-low column drive
//   keycode[4:0] last accepted key; [4]=1 hex digit in [3:0], [4]=0 function key
//   newkey       one-cycle strobe, keycode already stable when it rises
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [5:0] col_n,
    output logic [4:0] keycode,
    output logic       newkey
);

    localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);

    logic       w_scan_done;
    scan_res_t  w_result;
    logic [4:0] w_idx;
    logic       w_single;

    kp_state_t  r_state;
    logic [4:0] r_cand;
    logic [3:0] r_cnt;
    logic [3:0] r_relcnt;
    logic [4:0] r_keycode;
    logic       r_newkey;

    keypad_scan_core #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_row_n     (row_n),
        .o_col_n     (col_n),
        .o_scan_done (w_scan_done),
        .o_result    (w_result),
        .o_idx       (w_idx)
    );

    assign w_single = w_scan_done && (w_result == SCAN_SINGLE);

    // Keycode is loaded on entry to STROBE and newkey is raised from STROBE,
    // so the consumer always sees a settled keycode one cycle before the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cand    <= 5'd0;
            r_cnt     <= 4'd0;
            r_relcnt  <= 4'd0;
            r_keycode <= 5'h00;
            r_newkey  <= 1'b0;
        end else begin
            r_newkey <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_single) begin
                        r_cand <= w_idx;
                        if (DB_TARGET == 4'd1) begin
                            r_keycode <= index_to_keycode(w_idx);
                            r_cnt     <= 4'd0;
                            r_state   <= ST_STROBE;
                        end else begin
                            r_cnt   <= 4'd1;
                            r_state <= ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_scan_done) begin
                        if (w_single && (w_idx == r_cand)) begin
                            if (r_cnt + 4'd1 == DB_TARGET) begin
                                r_keycode <= index_to_keycode(r_cand);
                                r_cnt     <= 4'd0;
                                r_state   <= ST_STROBE;
                            end else begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end else begin
                            // Bounce, a different key or a chord: start over.
                            r_cnt   <= 4'd0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_STROBE: begin
                    r_newkey <= 1'b1;
                    r_relcnt <= 4'd0;
                    r_state  <= ST_HELD;
                end
                ST_HELD: begin
                    // No auto-repeat: any closure restarts the release count,
                    // so a second key is ignored until everything is let go.
                    if (w_scan_done) begin
                        if (w_result == SCAN_NONE) begin
                            if (r_relcnt + 4'd1 == DB_TARGET) begin
                                r_relcnt <= 4'd0;
                                r_state  <= ST_IDLE;
                            end else begin
                                r_relcnt <= r_relcnt + 4'd1;
                            end
                        end else begin
                            r_relcnt <= 4'd0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign keycode = r_keycode;
    assign newkey  = r_newkey;

endmodule

// File: doc/keypad_encoder.md
Name: keypad_encoder

Overview:
Keypad-side producer of the calculator key interface. It scans a 4-row x 6-column passive key matrix, synchronises and debounces the row returns, and encodes one debounced press as a 5-bit keycode. It then emits a single-cycle newkey strobe. Its outputs drive the calculator core's keycode/newkey inputs directly.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before advancing; must be >= 3 (two synchroniser flops plus settle).
DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a press, and consecutive empty scans needed to accept a release; range 1..15.

Ports:
clk  input  1  system clock (5 MHz nominal)
rst  input  1  reset, asynchronous, active-low
row_n  input  4  matrix row returns; asynchronous, pulled up, low = key closed to driven column
col_n  output  6  column drive, one-hot active-low
keycode  output  5  encoded key; [4]=1 hex digit 0-F in [3:0], [4]=0 function key
newkey  output  1  one-cycle strobe: keycode holds a new key

Behaviour:
- Reset (rst low, asynchronous) clears all outputs and internal state:
  - col_n=6'b111110 (column 0 driven), keycode=5'h00, newkey=0.
  - Scan counter=0, FSM=IDLE, debounce counters=0, synchroniser flops=4'hF.
- Key index = col*4 + row.
  - Indices 0-15 encode as {1'b1, index[3:0]}.
  - Indices 16-23 encode as: SQR 5'h01, CH_SIGN 5'h02, EQUALS 5'h03, CA 5'h04, MULTI 5'h09, MINUS 5'h0A, PLUS 5'h0B, CE 5'h0C.
- Scanning:
  - row_n passes through a 2-flop synchroniser.
  - The column slot counter runs 0..SCAN_DIV-1. The synchronised rows are sampled on the last cycle of the slot, then col_n rotates to the next column (5 wraps to 0).
  - One full scan = 6*SCAN_DIV cycles.
- Scan result, evaluated at the end of column 5: NONE (no closure), SINGLE(idx) (exactly one closure in the whole scan), or MULTI (two or more closures).
- FSM transitions are evaluated once per completed scan:
  - IDLE: SINGLE(idx) -> cand=idx, cnt=1, go to DEBOUNCE. NONE or MULTI -> stay.
  - DEBOUNCE: SINGLE(cand) -> cnt+1. If the new count reaches DEBOUNCE_SCANS, load keycode=map(cand), go to STROBE. Any other result -> IDLE, cnt=0, no output.
  - STROBE: lasts one cycle. newkey=1, keycode unchanged, then go to HELD. Keycode is therefore stable for >= 1 cycle before newkey and remains stable while newkey is high.
  - HELD: NONE -> relcnt+1; when relcnt reaches DEBOUNCE_SCANS, go to IDLE. SINGLE or MULTI -> relcnt=0. There is no auto-repeat; a second key pressed while the first is held is ignored until a full release.
- With DEBOUNCE_SCANS=1, a single SINGLE scan in IDLE loads keycode directly and goes to STROBE.
- keycode holds its last value until the next accepted key and is never cleared except by reset.
- newkey is exactly one cycle wide per accepted press and is never asserted in two consecutive cycles.
- Latency: from the first scan that sees a clean press to newkey is (DEBOUNCE_SCANS-1) scans + 1 cycle.
- Reset mid-DEBOUNCE or mid-HELD discards the candidate and emits no strobe. A key still held after reset is re-detected from IDLE and produces one new strobe.

Decomposition:
- Shared package keypad_pkg holds:
  - NUM_ROWS=4 and NUM_COLS=6.
  - The keycode localparams KEY_SQR, KEY_CHSIGN, KEY_EQUALS, KEY_CA, KEY_MULTI, KEY_MINUS, KEY_PLUS, KEY_CE.
  - The FSM state enum.
  - The function index_to_keycode.
- The calculator core and its benches import the same keycode constants.
- One sub-module, keypad_scan_core, owns the synchroniser, column rotation, slot counter and per-scan NONE/SINGLE/MULTI result with a one-cycle scan_done pulse. The top level holds the debounce FSM and output registers.

Test Plan:
All scenarios run with SCAN_DIV=4 and DEBOUNCE_SCANS=2 (scan = 24 cycles) against a matrix model that pulls row r low while col c is driven and key (c,r) is closed.
1. Reset -> col_n=6'b111110, keycode=5'h00, newkey=0. Key 3 held throughout reset -> no newkey while rst low.
2. Hold key (col1,row1) for 10 scans -> exactly one newkey with keycode=5'h15, within 2 scans of press. Release for 3 scans, press again -> a second single pulse.
3. Press (col5,row2) -> keycode=5'h0B (PLUS). Press (col3,row3) -> keycode=5'h1F. Each gets exactly one pulse.
4. Bounce: key 9 closed for 1 scan, open for 1 scan, closed for 1 scan, then open -> no newkey, keycode unchanged.
5. Keys 0 and 7 held together for 4 scans -> no newkey. Release key 0 while holding 7 -> one newkey with keycode=5'h17.
6. Assert rst during DEBOUNCE of key 20 -> no pulse, keycode=5'h00. Key still held after rst release -> one newkey with keycode=5'h09.
